// File: rtl/v2c_out_buffer.sv
// Output buffer between the row PE and the message-memory writer: a first-word fall-through FIFO of v2c words tagged with the layer index.
// Optional macro HD_ZERO_DETECT_EN adds hd_zero, which flags an iteration whose accepted hard decisions were all zero.
module v2c_out_buffer #(
    parameter  int QUAN_SIZE  = 4,
    parameter  int CN_DEGREE  = 10,
    parameter  int FIFO_DEPTH = 4,
    parameter  int LAYER_NUM  = 4,
    localparam int LAYER_BW   = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          read_clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [CN_DEGREE*QUAN_SIZE-1:0] in_v2c,
    input  logic [CN_DEGREE-1:0]          in_hd,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CN_DEGREE*QUAN_SIZE-1:0] out_v2c,
    output logic [CN_DEGREE-1:0]          out_hd,
    output logic [LAYER_BW-1:0]           out_layer,
    output logic                          iter_done,
    output logic [CNT_W-1:0]              fifo_count,
    output logic                          overflow
`ifdef HD_ZERO_DETECT_EN
    ,
    output logic                          hd_zero
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int V2C_W = CN_DEGREE * QUAN_SIZE;
    localparam int ENT_W = V2C_W + CN_DEGREE + LAYER_BW;

    logic [ENT_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [LAYER_BW-1:0] r_layer_cnt;
    logic                r_iter_done;
    logic                r_overflow;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_last_layer;
    logic [ENT_W-1:0]    w_head;

    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_push       = in_valid & ~w_full;
    assign w_pop        = out_ready & ~w_empty;
    assign w_last_layer = (r_layer_cnt == LAYER_BW'(LAYER_NUM - 1));
    assign w_head       = r_mem[r_rd_ptr];

    // Entry storage carries no reset; the empty-gating below keeps stale words off the outputs.
    always_ff @(posedge read_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_v2c, in_hd, r_layer_cnt};
        end
    end

    always_ff @(posedge read_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_layer_cnt <= '0;
            r_iter_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
                r_layer_cnt <= w_last_layer ? '0 : r_layer_cnt + LAYER_BW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_iter_done <= w_push & w_last_layer;
            // A word offered while full is lost; remember it until reset.
            if (in_valid & w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef HD_ZERO_DETECT_EN
    logic r_hd_acc;
    logic r_hd_zero;
    logic w_hd_all_zero;

    assign w_hd_all_zero = (in_hd == '0);

    // r_hd_acc holds "all zero so far" for the iteration in progress; it is published on the last layer.
    always_ff @(posedge read_clk or posedge rst) begin
        if (rst) begin
            r_hd_acc  <= 1'b1;
            r_hd_zero <= 1'b0;
        end else if (w_push) begin
            if (w_last_layer) begin
                r_hd_zero <= r_hd_acc & w_hd_all_zero;
                r_hd_acc  <= 1'b1;
            end else begin
                r_hd_acc  <= r_hd_acc & w_hd_all_zero;
            end
        end
    end

    assign hd_zero = r_hd_zero;
`endif

    assign in_ready   = ~w_full;
    assign out_valid  = ~w_empty;
    assign out_v2c    = w_empty ? '0 : w_head[ENT_W-1 -: V2C_W];
    assign out_hd     = w_empty ? '0 : w_head[LAYER_BW +: CN_DEGREE];
    assign out_layer  = w_empty ? '0 : w_head[LAYER_BW-1:0];
    assign iter_done  = r_iter_done;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_v2c_out_buffer.sv
// Directed bench for v2c_out_buffer at default parameters; hd_zero checks are included when HD_ZERO_DETECT_EN is defined.
module tb_v2c_out_buffer;

    logic        read_clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [39:0] in_v2c;
    logic [9:0]  in_hd;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_v2c;
    logic [9:0]  out_hd;
    logic [1:0]  out_layer;
    logic        iter_done;
    logic [2:0]  fifo_count;
    logic        overflow;
`ifdef HD_ZERO_DETECT_EN
    logic        hd_zero;
`endif

    int total = 0;
    int bad   = 0;

    logic [39:0] vec_v2c [4];
    logic [9:0]  vec_hd  [4];

    always #5 read_clk = ~read_clk;

    v2c_out_buffer dut (
        .read_clk   (read_clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_v2c     (in_v2c),
        .in_hd      (in_hd),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_v2c    (out_v2c),
        .out_hd     (out_hd),
        .out_layer  (out_layer),
        .iter_done  (iter_done),
        .fifo_count (fifo_count),
        .overflow   (overflow)
`ifdef HD_ZERO_DETECT_EN
        ,
        .hd_zero    (hd_zero)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge read_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_v2c[0] = 40'h0123456789; vec_hd[0] = 10'h3FF;
        vec_v2c[1] = 40'hFEDCBA9876; vec_hd[1] = 10'h155;
        vec_v2c[2] = 40'h0F0F0F0F0F; vec_hd[2] = 10'h2AA;
        vec_v2c[3] = 40'hA5A5A5A5A5; vec_hd[3] = 10'h001;

        rst = 1'b1; in_valid = 1'b0; in_v2c = '0; in_hd = '0; out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_iter_done", iter_done, 0);
        chk("rst_out_v2c", out_v2c, 0);
        rst = 1'b0;
        step();

        // single push, head visible right after the edge
        in_valid = 1'b1; in_v2c = vec_v2c[0]; in_hd = vec_hd[0];
        step();
        in_valid = 1'b0;
        chk("p1_out_valid", out_valid, 1);
        chk("p1_out_v2c", out_v2c, 40'h0123456789);
        chk("p1_out_hd", out_hd, 10'h3FF);
        chk("p1_out_layer", out_layer, 0);
        chk("p1_count", fifo_count, 1);
        step();
        chk("hold_out_v2c", out_v2c, 40'h0123456789);
        chk("hold_count", fifo_count, 1);

        // fill to full, iter_done after layer 3
        for (int i = 1; i < 4; i++) begin
            in_valid = 1'b1; in_v2c = vec_v2c[i]; in_hd = vec_hd[i];
            step();
            if (i == 2) chk("iter_done_early", iter_done, 0);
        end
        chk("full_iter_done", iter_done, 1);
        chk("full_count", fifo_count, 4);
        chk("full_in_ready", in_ready, 0);
        in_v2c = 40'h1111111111; in_hd = 10'h111;
        step();
        in_valid = 1'b0;
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", fifo_count, 4);
        chk("iter_done_cleared", iter_done, 0);
        chk("ovf_head_kept", out_v2c, 40'h0123456789);

        // drain in order with tags 0..3
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_v2c", i), out_v2c, vec_v2c[i]);
            chk($sformatf("drain%0d_hd", i), out_hd, vec_hd[i]);
            chk($sformatf("drain%0d_layer", i), out_layer, i);
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        chk("drained_valid", out_valid, 0);
        chk("drained_count", fifo_count, 0);
        chk("drained_v2c_zero", out_v2c, 0);
        chk("ovf_sticky", overflow, 1);

        // layer counter wrapped to 0; push A(0), B(1)
        in_valid = 1'b1; in_v2c = 40'hAAAAAAAAA0; in_hd = 10'h00A;
        step();
        chk("wrap_layer", out_layer, 0);
        in_v2c = 40'hBBBBBBBBB1; in_hd = 10'h00B;
        step();
        chk("two_count", fifo_count, 2);
        // push C with pop of A
        in_v2c = 40'hCCCCCCCCC2; in_hd = 10'h00C; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pp_count", fifo_count, 2);
        chk("pp_head_v2c", out_v2c, 40'hBBBBBBBBB1);
        chk("pp_head_layer", out_layer, 1);
        // pop B, then push D(3) and E(0) to reach full with C at head
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b1;
        in_v2c = 40'hDDDDDDDDD3; in_hd = 10'h00D;
        step();
        chk("d_iter_done", iter_done, 1);
        in_v2c = 40'hEEEEEEEEE0; in_hd = 10'h00E;
        step();
        chk("e_count", fifo_count, 3);
        in_v2c = 40'h2222222222; in_hd = 10'h022;
        step();
        chk("f_count", fifo_count, 4);
        // full: push and pop together, push rejected
        in_v2c = 40'h3333333333; in_hd = 10'h033; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("fullpp_count", fifo_count, 3);
        chk("fullpp_head_v2c", out_v2c, 40'hDDDDDDDDD3);
        chk("fullpp_head_layer", out_layer, 3);

        // asynchronous reset mid-stream
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_layer", out_layer, 0);
        step();
        rst = 1'b0;
        in_valid = 1'b1; in_v2c = 40'h4444444444; in_hd = 10'h044;
        step();
        in_valid = 1'b0;
        chk("post_rst_layer", out_layer, 0);
        chk("post_rst_v2c", out_v2c, 40'h4444444444);
        chk("post_rst_count", fifo_count, 1);

`ifdef HD_ZERO_DETECT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("hdz_rst", hd_zero, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_v2c = 40'h5; in_hd = 10'h000;
            step();
        end
        chk("hdz_iter_done1", iter_done, 1);
        chk("hdz_all_zero", hd_zero, 1);
        for (int i = 0; i < 4; i++) begin
            in_hd = (i == 1) ? 10'h004 : 10'h000;
            step();
            if (i == 2) chk("hdz_hold", hd_zero, 1);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("hdz_iter_done2", iter_done, 1);
        chk("hdz_nonzero", hd_zero, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/v2c_out_buffer.md
V2C_OUT_BUFFER -- requirements
Module: v2c_out_buffer

Interface
REQ-001 SHALL have parameter QUAN_SIZE, default 4: bits per v2c message.
REQ-002 SHALL have parameter CN_DEGREE, default 10: messages and hard decisions per row-PE output word.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: entries, power of two, at least 2.
REQ-004 SHALL have parameter LAYER_NUM, default 4: layers per decoding iteration; LAYER_BW = clog2(LAYER_NUM).
REQ-005 SHALL have port read_clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: row-PE output word present.
REQ-008 SHALL have port in_v2c, input, CN_DEGREE*QUAN_SIZE bits: packed vnu0..vnu9 v2c messages, vnu0 in the LSBs.
REQ-009 SHALL have port in_hd, input, CN_DEGREE bits: hard decisions, bit i = vnu i.
REQ-010 SHALL have port in_ready, output, 1 bit: buffer can accept.
REQ-011 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): handshake toward the message-memory writer.
REQ-012 SHALL have ports out_v2c, out_hd and out_layer (outputs; widths as in_v2c, in_hd and LAYER_BW): head entry and its layer tag.
REQ-013 SHALL have port iter_done, output, 1 bit: single-cycle pulse at the end of an iteration.
REQ-014 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-015 SHALL have port overflow, output, 1 bit: sticky drop flag.

Function
REQ-016 SHALL store {in_v2c, in_hd, layer_cnt} into a FIFO of FIFO_DEPTH entries on push = in_valid & in_ready.
REQ-017 SHALL drive in_ready = (fifo_count != FIFO_DEPTH) combinationally; at full, no push occurs even if a pop occurs in the same cycle.
REQ-018 SHALL operate first-word fall-through: out_valid = (fifo_count != 0); out_v2c, out_hd and out_layer show the head entry with zero added latency. An entry pushed at edge N is visible at out_* after edge N.
REQ-019 SHALL pop on out_valid & out_ready; a pop at empty has no effect.
REQ-020 SHALL leave fifo_count unchanged on a simultaneous push and pop, with data order preserved.
REQ-021 SHALL wrap the read and write pointers modulo FIFO_DEPTH.
REQ-022 SHALL tag each push with layer_cnt, which increments on each push and wraps from LAYER_NUM-1 to 0.
REQ-023 SHALL pulse iter_done high for exactly one cycle, on the cycle after the push tagged LAYER_NUM-1.
REQ-024 SHALL set overflow on the edge where in_valid=1 while the FIFO is full; the word is dropped and layer_cnt does not advance. overflow stays set until reset.
REQ-025 SHALL hold out_* stable while out_valid=1 and out_ready=0.

Reset
REQ-026 SHALL, while rst=1 (asynchronously), force the pointers, fifo_count, layer_cnt, iter_done and overflow to 0, which gives out_valid=0 and in_ready=1.
REQ-027 SHALL drive out_v2c, out_hd and out_layer to 0 while empty, including during reset.
REQ-028 SHALL discard in-flight entries when reset is asserted mid-operation; the first push after release is tagged layer 0.

Configuration
REQ-029 SHALL support macro HD_ZERO_DETECT_EN. When defined, it adds output hd_zero (1 bit, reset 0). hd_zero updates together with iter_done: it is 1 if every in_hd accepted across that iteration's LAYER_NUM pushes was all-zero, else 0, and it holds until the next iteration completes.
REQ-030 SHALL, when HD_ZERO_DETECT_EN is undefined, omit the hd_zero port and its accumulation logic; all other behaviour is identical.

Verification
REQ-031 Reset, then push 1 word (in_v2c=40'h0123456789, in_hd=10'h3FF) with out_ready=0 -> next cycle out_valid=1, out_v2c=40'h0123456789, out_layer=0, fifo_count=1.
REQ-032 4 pushes with out_ready=0 -> fifo_count=4, in_ready=0; a 5th in_valid -> overflow=1, fifo_count stays 4; drain 4 words -> data in order, tags 0,1,2,3.
REQ-033 4 pushes (layers 0..3) -> iter_done high exactly one cycle, after the 4th push; the 5th push is tagged 0.
REQ-034 fifo_count=2, push and pop in the same cycle -> fifo_count=2 and head advances; at full, push and pop in the same cycle -> push rejected, fifo_count=3.
REQ-035 rst pulsed mid-stream with fifo_count=3 -> immediately out_valid=0, fifo_count=0, overflow=0; the next push is tagged 0.
REQ-036 With HD_ZERO_DETECT_EN: 4 pushes with in_hd=0 -> hd_zero=1 with iter_done; next iteration with one push of in_hd=10'h004 -> hd_zero=0.
